// File: rtl/single_in_to_x_out_pkg.sv
// Shared definitions for the serial-to-parallel word assembler.
package single_in_to_x_out_pkg;

    localparam int DEFAULT_NUM_OUTS = 8;

    // Width of a counter that must reach n-1; never less than one bit.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/single_in_to_x_out.sv
// Serial-to-parallel assembler: collects LSB-first bits into NUM_OUTS-bit words
// and presents each word on a registered valid/ready output with overrun detection.
module single_in_to_x_out
    import single_in_to_x_out_pkg::*;
#(
    parameter int NUM_OUTS = DEFAULT_NUM_OUTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    input  logic                in_en,
    input  logic                align,
    output logic [NUM_OUTS-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int                IDX_W    = idxWidth(NUM_OUTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OUTS - 1);

    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_OUTS-2:0] buf_q, buf_d;
    logic [NUM_OUTS-1:0] out_q;
    logic                outValid_q;
    logic                overrun_q;

    logic                wordDone;
    logic                canLoad;
    logic                loadWord;
    logic                dropWord;
    logic [NUM_OUTS-1:0] completedWord;

    // An aligning bit is always bit 0 of a fresh word, so it can never complete one.
    assign wordDone      = in_en && !align && (idx_q == LAST_IDX);
    assign canLoad       = !outValid_q || out_ready;
    assign loadWord      = wordDone && canLoad;
    assign dropWord      = wordDone && !canLoad;
    assign completedWord = {in, buf_q};

    always_comb begin
        idx_d = idx_q;
        if (align) begin
            idx_d = in_en ? IDX_W'(1) : '0;
        end else if (in_en) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    // The final bit of a word goes straight to the output register, so the
    // buffer only needs the first NUM_OUTS-1 positions.
    always_comb begin
        buf_d = buf_q;
        if (align) begin
            buf_d    = '0;
            buf_d[0] = in_en & in;
        end else if (in_en) begin
            for (int i = 0; i < NUM_OUTS - 1; i++) begin
                if (idx_q == IDX_W'(i)) buf_d[i] = in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) buf_q <= '0;
        else     buf_q <= buf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            outValid_q <= 1'b0;
        end else if (loadWord) begin
            out_q      <= completedWord;
            outValid_q <= 1'b1;
        end else if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    // A dropped word wins over a simultaneous clear so no overrun goes unreported.
    always_ff @(posedge clk) begin
        if (rst)              overrun_q <= 1'b0;
        else if (dropWord)    overrun_q <= 1'b1;
        else if (overrun_clr) overrun_q <= 1'b0;
    end

    assign out       = out_q;
    assign out_valid = outValid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_single_in_to_x_out.sv
// Directed self-checking bench for single_in_to_x_out with NUM_OUTS=8 and NUM_OUTS=5.
module tb_single_in_to_x_out;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inBit = 1'b0;
    logic       inEn = 1'b0;
    logic       align = 1'b0;
    logic       outReady = 1'b0;
    logic       overrunClr = 1'b0;
    logic [7:0] out8;
    logic       valid8, ovr8;
    logic [4:0] out5;
    logic       valid5, ovr5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    single_in_to_x_out #(.NUM_OUTS(8)) dut8 (
        .clk(clk), .rst(rst), .in(inBit), .in_en(inEn), .align(align),
        .out(out8), .out_valid(valid8), .out_ready(outReady),
        .overrun(ovr8), .overrun_clr(overrunClr)
    );

    single_in_to_x_out #(.NUM_OUTS(5)) dut5 (
        .clk(clk), .rst(rst), .in(inBit), .in_en(inEn), .align(align),
        .out(out5), .out_valid(valid5), .out_ready(outReady),
        .overrun(ovr5), .overrun_clr(overrunClr)
    );

    // One clock of stimulus; outputs are stable 1ns after the edge.
    task automatic driveCycle(input logic b, input logic en, input logic al,
                              input logic rdy, input logic clr);
        inBit = b; inEn = en; align = al; outReady = rdy; overrunClr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBits8(input logic [7:0] w, input logic rdy, input int n);
        for (int i = 0; i < n; i++) driveCycle(w[i], 1'b1, 1'b0, rdy, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        driveCycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        driveCycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (out8 !== 8'h00) begin errors++; $display("[TB] FAIL reset_out: got %h expected %h", out8, 8'h00); end
        checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid8); end
        checks++; if (ovr8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", ovr8); end
    endtask

    task automatic test_basic();
        sendBits8(8'hA5, 1'b1, 7);
        checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", valid8); end
        driveCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (valid8 !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", valid8); end
        checks++; if (out8 !== 8'hA5) begin errors++; $display("[TB] FAIL basic_out: got %h expected %h", out8, 8'hA5); end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_clear: got %b expected 0", valid8); end
        checks++; if (out8 !== 8'hA5) begin errors++; $display("[TB] FAIL basic_out_hold: got %h expected %h", out8, 8'hA5); end
    endtask

    task automatic test_back_to_back();
        sendBits8(8'h3C, 1'b1, 8);
        checks++; if (valid8 !== 1'b1 || out8 !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_first: got valid=%b out=%h expected valid=1 out=3c", valid8, out8); end
        sendBits8(8'hC3, 1'b1, 8);
        checks++; if (valid8 !== 1'b1 || out8 !== 8'hC3) begin errors++; $display("[TB] FAIL b2b_second: got valid=%b out=%h expected valid=1 out=c3", valid8, out8); end
        checks++; if (ovr8 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", ovr8); end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        doReset();
        sendBits8(8'h11, 1'b0, 8);
        checks++; if (valid8 !== 1'b1 || out8 !== 8'h11) begin errors++; $display("[TB] FAIL ovr_first: got valid=%b out=%h expected valid=1 out=11", valid8, out8); end
        sendBits8(8'h22, 1'b0, 8);
        checks++; if (out8 !== 8'h11 || valid8 !== 1'b1) begin errors++; $display("[TB] FAIL ovr_hold: got valid=%b out=%h expected valid=1 out=11", valid8, out8); end
        checks++; if (ovr8 !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", ovr8); end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (ovr8 !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", ovr8); end
        // Completion coincides with the handshake: new word replaces the old with no gap.
        sendBits8(8'h33, 1'b0, 7);
        driveCycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (valid8 !== 1'b1 || out8 !== 8'h33) begin errors++; $display("[TB] FAIL ovr_swap: got valid=%b out=%h expected valid=1 out=33", valid8, out8); end
        checks++; if (ovr8 !== 1'b0) begin errors++; $display("[TB] FAIL ovr_swap_flag: got %b expected 0", ovr8); end
        // A drop and a clear in the same cycle leave the flag set.
        sendBits8(8'h44, 1'b0, 7);
        driveCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (ovr8 !== 1'b1 || out8 !== 8'h33) begin errors++; $display("[TB] FAIL ovr_clr_race: got ovr=%b out=%h expected ovr=1 out=33", ovr8, out8); end
    endtask

    task automatic test_align();
        doReset();
        driveCycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        driveCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        driveCycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        driveCycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            driveCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            if (i < 6) begin
                checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL align_early_valid%0d: got %b expected 0 out=%h", i, valid8, out8); end
            end
        end
        checks++; if (valid8 !== 1'b1 || out8 !== 8'hFF) begin errors++; $display("[TB] FAIL align_word: got valid=%b out=%h expected valid=1 out=ff", valid8, out8); end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midword();
        doReset();
        sendBits8(8'hA5, 1'b0, 8);
        sendBits8(8'h0F, 1'b0, 4);
        checks++; if (valid8 !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_valid: got %b expected 1", valid8); end
        rst = 1'b1;
        driveCycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        checks++; if (out8 !== 8'h00 || valid8 !== 1'b0 || ovr8 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_clear: got out=%h valid=%b ovr=%b expected 00/0/0", out8, valid8, ovr8); end
        sendBits8(8'h5A, 1'b1, 8);
        checks++; if (valid8 !== 1'b1 || out8 !== 8'h5A) begin errors++; $display("[TB] FAIL rstmid_clean: got valid=%b out=%h expected valid=1 out=5a", valid8, out8); end
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_num5();
        logic [4:0] w1;
        logic [4:0] w2;
        w1 = 5'b10110;
        w2 = 5'b01001;
        doReset();
        for (int i = 0; i < 5; i++) begin
            driveCycle(w1[i], 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 4) begin
                checks++; if (valid5 !== 1'b1 || out5 !== 5'h16) begin errors++; $display("[TB] FAIL n5_word1: got valid=%b out=%h expected valid=1 out=16", valid5, out5); end
            end
            driveCycle(~w1[i], 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 3) begin
                checks++; if (valid5 !== 1'b0) begin errors++; $display("[TB] FAIL n5_early_valid: got %b expected 0", valid5); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            driveCycle(w2[i], 1'b1, 1'b0, 1'b1, 1'b0);
            driveCycle(~w2[i], 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (out5 !== 5'h09 || ovr5 !== 1'b0) begin errors++; $display("[TB] FAIL n5_word2: got out=%h ovr=%b expected out=09 ovr=0", out5, ovr5); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_align();
        test_reset_midword();
        test_num5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
